// File: rtl/mem_arbiter12_if.sv
// mem_arbiter12_if: requester and memory signal bundle for mem_arbiter12.
// Ports: p0_*/p1_* request side, mem_* memory side, busy/grant status.
// Modports: master = arbiter, slave = requesters plus memory.
interface mem_arbiter12_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 12
);
    logic                  p0_rd;
    logic                  p0_wr;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_ack;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_err;

    logic                  p1_rd;
    logic                  p1_wr;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ack;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_err;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  grant;

    modport master (
        input  p0_rd, p0_wr, p0_addr, p0_wdata,
        input  p1_rd, p1_wr, p1_addr, p1_wdata,
        input  mem_ack, mem_rdata,
        output p0_ack, p0_rdata, p0_err,
        output p1_ack, p1_rdata, p1_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output busy, grant
    );

    modport slave (
        output p0_rd, p0_wr, p0_addr, p0_wdata,
        output p1_rd, p1_wr, p1_addr, p1_wdata,
        output mem_ack, mem_rdata,
        input  p0_ack, p0_rdata, p0_err,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  busy, grant
    );
endinterface

// File: rtl/mem_arbiter12.sv
// mem_arbiter12: two-port round-robin arbiter for the Computer12 memory bus.
// Ports: clk, rst (async, active-low), bus (mem_arbiter12_if.master).
// Option: define ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles
// with rdata all ones and pN_err set; otherwise WAIT never times out.
module mem_arbiter12 #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 12,
    parameter int TIMEOUT    = 255
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter12_if.master bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter12: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;

    // last_vld is clear until the first grant so that port 0
    // wins the first tie after reset even though last resets to 0.
    logic last;
    logic last_vld;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt;
`endif

    logic                  act0;
    logic                  act1;
    logic                  win;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        act0 = bus.p0_rd | bus.p0_wr;
        act1 = bus.p1_rd | bus.p1_wr;
        win  = act1;
        if (act0 && act1) begin
            win = last_vld ? ~last : 1'b0;
        end
        sel_wr    = win ? bus.p1_wr    : bus.p0_wr;
        sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last          <= 1'b0;
            last_vld      <= 1'b0;
            bus.grant     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.p0_ack    <= 1'b0;
            bus.p1_ack    <= 1'b0;
            bus.p0_err    <= 1'b0;
            bus.p1_err    <= 1'b0;
            bus.p0_rdata  <= '0;
            bus.p1_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.p0_err <= 1'b0;
            bus.p1_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (act0 || act1) begin
                        bus.grant     <= win;
                        last          <= win;
                        last_vld      <= 1'b1;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        // Write takes priority when rd and wr are both set.
                        bus.mem_wr    <= sel_wr;
                        bus.mem_rd    <= ~sel_wr;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // A real ack beats a timeout in the same cycle.
                    if (bus.mem_ack) begin
                        if (bus.grant) begin
                            bus.p1_rdata <= bus.mem_rdata;
                        end else begin
                            bus.p0_rdata <= bus.mem_rdata;
                        end
                        bus.p0_ack <= ~bus.grant;
                        bus.p1_ack <= bus.grant;
                        state      <= RESP;
                    end else if (state == ISSUE) begin
                        state <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        if (bus.grant) begin
                            bus.p1_rdata <= '1;
                        end else begin
                            bus.p0_rdata <= '1;
                        end
                        bus.p0_err <= ~bus.grant;
                        bus.p1_err <= bus.grant;
                        bus.p0_ack <= ~bus.grant;
                        bus.p1_ack <= bus.grant;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
